c2c_responder: RTL and testbench
================================

Name: c2c_responder

Overview:
Slave-side responder for the chip-to-chip request/ack/valid link. It answers an incoming request with a delayed ack and captures the 3-bit symbol, with even parity, when valid arrives. Accepted symbols go into a small receive FIFO that local logic drains, such as the display path. A timeout, parity checking and sticky error flags make the link robust to a missing or misbehaving initiator.

Parameters:
DATA_W, 3, symbol width.
ACK_DELAY, 100_000_000, cycles from request detection to ack assertion (1 s at 100 MHz).
TIMEOUT, 200_000_000, maximum cycles in WAIT_DATA before abort.
FIFO_DEPTH, 4, receive FIFO entries (power of 2).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
request  in  1  initiator request (async, from other board)
valid  in  1  initiator data valid (async)
data_in  in  DATA_W  initiator data (async, stable while valid)
par_in  in  1  even-parity bit over data_in
ack  out  1  handshake ack to initiator (registered)
notice  out  1  LED: high while in DELAY
rd_en  in  1  pop one FIFO entry
rd_data  out  DATA_W  FIFO head (valid when !fifo_empty)
fifo_empty  out  1  FIFO empty
fifo_full  out  1  FIFO full
fifo_count  out  log2(FIFO_DEPTH)+1  occupancy
last_data  out  DATA_W  last symbol accepted into FIFO
parity_err  out  1  sticky: symbol failed parity
overflow  out  1  sticky: symbol dropped, FIFO full
timeout  out  1  sticky: WAIT_DATA expired
clr_err  in  1  clears all three sticky flags

Behaviour:
- Reset values (clk edge with rst_n=0): state=IDLE. ack, notice, fifo_count, last_data, all sticky flags = 0. fifo_empty=1, fifo_full=0, counter=0, synchronizers=0. Reset mid-transfer aborts immediately. ack drops on the next edge.
- Synchronizers: request, valid, data_in and par_in each pass through 2 flops. FSM sees pin changes 2 cycles later (req_s, valid_s, data_s, par_s).
- State IDLE: ack=0, notice=0. If req_s=1, go to DELAY and clear the counter.
- State DELAY: notice=1. The counter increments each cycle.
  - If req_s=0, return to IDLE with no ack.
  - When counter==ACK_DELAY-1, go to WAIT_DATA and set ack=1 on that edge. ack rises exactly ACK_DELAY cycles after DELAY entry.
- State WAIT_DATA: ack=1. The counter restarts at 0.
  - If valid_s=1, evaluate the symbol:
    - Parity check: ^{data_s,par_s} must be 0.
    - Parity fail: set parity_err, no push.
    - FIFO full: set overflow, no push.
    - Otherwise: push data_s and update last_data.
    - Then go to RELEASE.
  - If counter==TIMEOUT-1 with valid_s=0: set timeout, ack=0, go to IDLE.
- State RELEASE: ack held at 1 until valid_s=0. Then ack=0 and go to IDLE.
  - Exactly one symbol is accepted per handshake, however long valid stays high.
- FIFO:
  - Circular buffer, DATA_W x FIFO_DEPTH, with pointers that wrap modulo FIFO_DEPTH.
  - Push occurs only on the WAIT_DATA valid edge. Pop occurs on rd_en when !fifo_empty; rd_en while empty is ignored.
  - Simultaneous push and pop:
    - When full: both execute, count unchanged, and no overflow.
    - When empty: push only; the pop is ignored.
  - rd_data is combinational from the head entry.
- Sticky flags: clr_err=1 clears all three flags. If set and clear happen in the same cycle, set wins.
- Width rules: the counter is wide enough for max(ACK_DELAY, TIMEOUT). fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
- ACK_DELAY=4, TIMEOUT=10. request=1 at t0 → notice=1 from t0+3; ack rises at t0+7. Then data_in=3'b101, par_in=0, valid=1 → FIFO count 1, rd_data=5, last_data=5, ack falls 3 cycles after valid drops.
- request pulsed high 3 cycles (after sync, still in DELAY) then 0 → FSM returns to IDLE, ack never asserts, notice drops.
- Handshake with data_in=3'b011, par_in=1 (odd) → parity_err=1, fifo_count stays 0. Pulse clr_err → parity_err=0.
- Five handshakes with data 1,2,3,4,5 and no rd_en → count=4, fifo_full=1, overflow=1, last_data=4. Four rd_en pops return 1,2,3,4, then fifo_empty=1. Wrap-around is verified on a following push.
- Ack given, valid never asserted → after 10 cycles in WAIT_DATA: timeout=1, ack=0, state IDLE. A new request is then serviced normally.
- FIFO full, rd_en=1 during a valid push of 6 → count stays 4, no overflow, head advances, tail entry=6. Separately, rst_n=0 during RELEASE → ack=0 next edge, all flags and count=0.

Source files
------------

// File: rtl/c2c_responder.sv
// Slave-side responder for the chip-to-chip request/ack/valid link.
// Delays ack after a request, captures one parity-checked symbol per handshake into a small FIFO.
module c2c_responder #(
    parameter int unsigned DATA_W     = 3,
    parameter int unsigned ACK_DELAY  = 100_000_000,
    parameter int unsigned TIMEOUT    = 200_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          request,
    input  logic                          valid,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          par_in,
    output logic                          ack,
    output logic                          notice,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [DATA_W-1:0]             last_data,
    output logic                          parity_err,
    output logic                          overflow,
    output logic                          timeout,
    input  logic                          clr_err
);

    localparam int unsigned MAX_CNT = (ACK_DELAY > TIMEOUT) ? ACK_DELAY : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W   = PTR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DELAY   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ack;
    logic              r_notice;
    logic              r_req_m, r_req_s;
    logic              r_val_m, r_val_s;
    logic [DATA_W-1:0] r_dat_m, r_dat_s;
    logic              r_par_m, r_par_s;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0]  r_count;
    logic [DATA_W-1:0] r_last;
    logic              r_par_err, r_ovf, r_to;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ack_nxt;
    logic              w_push, w_pop, w_full, w_par_ok;
    logic              w_set_par, w_set_ovf, w_set_to;

    assign w_full   = (r_count == OCC_W'(FIFO_DEPTH));
    assign w_pop    = rd_en && (r_count != '0);
    assign w_par_ok = ~^{r_dat_s, r_par_s};

    // Handshake FSM next-state and event decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = r_ack;
        w_push      = 1'b0;
        w_set_par   = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_to    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ack_nxt = 1'b0;
                if (r_req_s) begin
                    w_state_nxt = S_DELAY;
                    w_cnt_nxt   = '0;
                end
            end
            S_DELAY: begin
                if (!r_req_s) begin
                    w_state_nxt = S_IDLE;
                    w_ack_nxt   = 1'b0;
                end else if (r_cnt == CNT_W'(ACK_DELAY - 1)) begin
                    w_state_nxt = S_WAIT;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (r_val_s) begin
                    w_state_nxt = S_RELEASE;
                    if (!w_par_ok)
                        w_set_par = 1'b1;
                    else if (w_full && !w_pop)
                        w_set_ovf = 1'b1;
                    else
                        w_push = 1'b1;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_ack_nxt   = 1'b0;
                    w_set_to    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (!r_val_s) begin
                    w_state_nxt = S_IDLE;
                    w_ack_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ack_nxt   = 1'b0;
            end
        endcase
    end

    // State, counter and two-flop input synchronizers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ack    <= 1'b0;
            r_notice <= 1'b0;
            r_req_m  <= 1'b0;
            r_req_s  <= 1'b0;
            r_val_m  <= 1'b0;
            r_val_s  <= 1'b0;
            r_dat_m  <= '0;
            r_dat_s  <= '0;
            r_par_m  <= 1'b0;
            r_par_s  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ack    <= w_ack_nxt;
            r_notice <= (w_state_nxt == S_DELAY);
            r_req_m  <= request;
            r_req_s  <= r_req_m;
            r_val_m  <= valid;
            r_val_s  <= r_val_m;
            r_dat_m  <= data_in;
            r_dat_s  <= r_dat_m;
            r_par_m  <= par_in;
            r_par_s  <= r_par_m;
        end
    end

    // Receive FIFO bookkeeping and sticky flags (set beats clear)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_last    <= '0;
            r_par_err <= 1'b0;
            r_ovf     <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_last   <= r_dat_s;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + OCC_W'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - OCC_W'(1);
            r_par_err <= w_set_par || (r_par_err && !clr_err);
            r_ovf     <= w_set_ovf || (r_ovf && !clr_err);
            r_to      <= w_set_to  || (r_to && !clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_dat_s;
    end

    assign ack        = r_ack;
    assign notice     = r_notice;
    assign rd_data    = r_mem[r_rd_ptr];
    assign fifo_empty = (r_count == '0);
    assign fifo_full  = w_full;
    assign fifo_count = r_count;
    assign last_data  = r_last;
    assign parity_err = r_par_err;
    assign overflow   = r_ovf;
    assign timeout    = r_to;

endmodule

// File: tb/tb_c2c_responder.sv
// Directed bench for c2c_responder with short ACK_DELAY/TIMEOUT.
module tb_c2c_responder;

    logic       clk = 1'b0;
    logic       rst_n, request, valid, par_in, rd_en, clr_err;
    logic [2:0] data_in;
    logic       ack, notice, fifo_empty, fifo_full;
    logic [2:0] rd_data, last_data;
    logic [2:0] fifo_count;
    logic       parity_err, overflow, timeout;

    int n_total = 0;
    int n_bad   = 0;

    c2c_responder #(.DATA_W(3), .ACK_DELAY(4), .TIMEOUT(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .request(request), .valid(valid),
        .data_in(data_in), .par_in(par_in), .ack(ack), .notice(notice),
        .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .last_data(last_data),
        .parity_err(parity_err), .overflow(overflow), .timeout(timeout),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        for (int i = 0; i < 60 && ack !== lvl; i++) tick(1);
        chk(tag, 32'(ack), 32'(lvl));
    endtask

    task automatic do_hs(input logic [2:0] d, input logic p);
        request = 1'b1;
        wait_ack(1'b1, "hs_ack_hi");
        data_in = d; par_in = p; valid = 1'b1;
        tick(4);
        valid = 1'b0; request = 1'b0;
        wait_ack(1'b0, "hs_ack_lo");
        tick(1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
    endtask

    task automatic pop_chk(input logic [2:0] exp, input string tag);
        chk(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; request = 1'b0; valid = 1'b0; par_in = 1'b0;
        rd_en = 1'b0; clr_err = 1'b0; data_in = 3'd0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_notice", 32'(notice), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_flags", 32'({parity_err, overflow, timeout}), 0);
        chk("rst_last", 32'(last_data), 0);

        // Basic handshake: notice at t0+3, ack at t0+7
        request = 1'b1;
        tick(2); chk("notice_t2", 32'(notice), 0);
        tick(1); chk("notice_t3", 32'(notice), 1);
        tick(3); chk("ack_t6", 32'(ack), 0);
        tick(1); chk("ack_t7", 32'(ack), 1);
        chk("notice_off_wait", 32'(notice), 0);
        data_in = 3'b101; par_in = 1'b0; valid = 1'b1;
        tick(3);
        chk("t1_count", 32'(fifo_count), 1);
        chk("t1_rd", 32'(rd_data), 5);
        chk("t1_last", 32'(last_data), 5);
        valid = 1'b0; request = 1'b0;
        tick(2); chk("t1_ack_hold", 32'(ack), 1);
        tick(1); chk("t1_ack_fall", 32'(ack), 0);
        pop_chk(3'd5, "t1_pop");
        chk("t1_empty", 32'(fifo_empty), 1);

        // Short request pulse aborts DELAY without ack
        request = 1'b1;
        tick(3); chk("abort_notice", 32'(notice), 1);
        request = 1'b0;
        tick(3);
        chk("abort_notice_off", 32'(notice), 0);
        chk("abort_ack", 32'(ack), 0);
        tick(6); chk("abort_ack_late", 32'(ack), 0);

        // Odd parity rejected
        do_hs(3'b011, 1'b1);
        chk("par_err", 32'(parity_err), 1);
        chk("par_count", 32'(fifo_count), 0);
        pulse_clr();
        chk("par_clr", 32'(parity_err), 0);

        // Fill to overflow
        do_hs(3'd1, 1'b1);
        do_hs(3'd2, 1'b1);
        do_hs(3'd3, 1'b0);
        do_hs(3'd4, 1'b1);
        do_hs(3'd5, 1'b0);
        chk("fill_count", 32'(fifo_count), 4);
        chk("fill_full", 32'(fifo_full), 1);
        chk("fill_ovf", 32'(overflow), 1);
        chk("fill_last", 32'(last_data), 4);
        pop_chk(3'd1, "drain0");
        pop_chk(3'd2, "drain1");
        pop_chk(3'd3, "drain2");
        pop_chk(3'd4, "drain3");
        chk("drain_empty", 32'(fifo_empty), 1);
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        chk("empty_pop_ignored", 32'(fifo_count), 0);
        pulse_clr();
        chk("ovf_clr", 32'(overflow), 0);
        do_hs(3'd7, 1'b1);
        chk("wrap_rd", 32'(rd_data), 7);
        chk("wrap_count", 32'(fifo_count), 1);

        // Timeout in WAIT_DATA
        request = 1'b1;
        wait_ack(1'b1, "to_ack_hi");
        tick(9);
        chk("to_ack_before", 32'(ack), 1);
        chk("to_flag_before", 32'(timeout), 0);
        tick(1);
        chk("to_ack_after", 32'(ack), 0);
        chk("to_flag", 32'(timeout), 1);
        request = 1'b0;
        tick(5);
        pulse_clr();
        chk("to_clr", 32'(timeout), 0);
        do_hs(3'd3, 1'b0);
        chk("to_recover_count", 32'(fifo_count), 2);
        chk("to_recover_last", 32'(last_data), 3);

        // Push while full with simultaneous pop
        do_hs(3'd1, 1'b1);
        do_hs(3'd2, 1'b1);
        chk("full_again", 32'(fifo_full), 1);
        request = 1'b1;
        wait_ack(1'b1, "fp_ack_hi");
        data_in = 3'd6; par_in = 1'b0; valid = 1'b1;
        tick(2);
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        chk("fp_count", 32'(fifo_count), 4);
        chk("fp_ovf", 32'(overflow), 0);
        chk("fp_head", 32'(rd_data), 3);
        chk("fp_last", 32'(last_data), 6);
        tick(1);
        valid = 1'b0; request = 1'b0;
        wait_ack(1'b0, "fp_ack_lo");
        tick(1);
        pop_chk(3'd3, "fp_pop0");
        pop_chk(3'd1, "fp_pop1");
        pop_chk(3'd2, "fp_pop2");
        chk("fp_tail", 32'(rd_data), 6);

        // Reset during RELEASE
        request = 1'b1;
        wait_ack(1'b1, "rr_ack_hi");
        data_in = 3'b011; par_in = 1'b1; valid = 1'b1;
        tick(4);
        chk("rr_ack_release", 32'(ack), 1);
        chk("rr_par", 32'(parity_err), 1);
        rst_n = 1'b0;
        tick(1);
        chk("rr_ack", 32'(ack), 0);
        chk("rr_flags", 32'({parity_err, overflow, timeout}), 0);
        chk("rr_count", 32'(fifo_count), 0);
        chk("rr_empty", 32'(fifo_empty), 1);
        valid = 1'b0; request = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("rr_idle_ack", 32'(ack), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
